// File: rtl/param_unlock_fsm.sv
// Serial password-unlock controller. A password of PWD_LEN bits arrives
// MSB first over a valid/ready bit stream and is compared with PASSWORD.
// The FSM has two states. COLLECT gathers frames of PWD_LEN bits. LOCKOUT
// is entered after MAX_TRIES consecutive wrong entries and lasts a fixed time.
// A partial entry that stays idle too long is discarded.
module param_unlock_fsm #(
  parameter int                 PWD_LEN        = 4,
  parameter logic [PWD_LEN-1:0] PASSWORD       = 4'b1011,
  parameter int                 MAX_TRIES      = 3,
  parameter int                 LOCKOUT_CYCLES = 16,
  parameter int                 TIMEOUT_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             serial_valid,
  input  logic                             serial_data,
  output logic                             serial_ready,
  output logic                             unlock,
  output logic                             pwd_incorrect,
  output logic                             locked_out,
  output logic                             entry_timeout,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int CNT_W  = $clog2(PWD_LEN);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(PWD_LEN - 1);
  localparam logic [FAIL_W-1:0] LAST_TRY   = FAIL_W'(MAX_TRIES - 1);
  localparam logic [FAIL_W-1:0] ALL_TRIES  = FAIL_W'(MAX_TRIES);
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {
    COLLECT = 1'b0,
    LOCKOUT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PWD_LEN-2:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                timeout_q, timeout_d;
  logic [PWD_LEN-1:0]  shifted;
  logic                accept;

  assign serial_ready  = (state_q == COLLECT) & reset;
  assign accept        = serial_valid & serial_ready;
  assign shifted       = {shift_q, serial_data};
  assign locked_out    = (state_q == LOCKOUT);
  assign entry_timeout = timeout_q;
  assign fail_count    = fail_q;

  // State register: reset throws away any partial entry, count or lockout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= COLLECT;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      fail_q    <= '0;
      lock_q    <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      fail_q    <= fail_d;
      lock_q    <= lock_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic and Mealy verdict pulses. The final bit is judged in
  // its own cycle because it is combined with the stored shift contents.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    fail_d        = fail_q;
    lock_d        = lock_q;
    idle_d        = idle_q;
    timeout_d     = 1'b0;
    unlock        = 1'b0;
    pwd_incorrect = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          idle_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            if (shifted == PASSWORD) begin
              unlock = 1'b1;
              fail_d = '0;
            end else begin
              pwd_incorrect = 1'b1;
              if (fail_q == LAST_TRY) begin
                fail_d  = ALL_TRIES;
                lock_d  = LOCK_LOAD;
                state_d = LOCKOUT;
              end else begin
                fail_d = fail_q + 1'b1;
              end
            end
          end else begin
            shift_d   = shifted[PWD_LEN-2:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (TIMEOUT_EN && (bit_cnt_q != '0)) begin
          if (idle_q == IDLE_LAST) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end

      LOCKOUT: begin
        if (lock_q == '0) begin
          state_d   = COLLECT;
          fail_d    = '0;
          bit_cnt_d = '0;
          shift_d   = '0;
          idle_d    = '0;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_param_unlock_fsm.sv
// Directed bench for param_unlock_fsm. It uses two instances. The first has
// the default parameters. The second has a 6-bit password and no timeout.
module tb_param_unlock_fsm;

  logic       clk;
  logic       reset;
  logic       valid1, data1, valid2, data2;
  logic       ready1, unlock1, incorrect1, locked1, timeout1;
  logic       ready2, unlock2, incorrect2, locked2, timeout2;
  logic [1:0] failCount1, failCount2;

  int checksTotal  = 0;
  int checksPassed = 0;

  param_unlock_fsm dutA (
    .clk(clk), .reset(reset),
    .serial_valid(valid1), .serial_data(data1), .serial_ready(ready1),
    .unlock(unlock1), .pwd_incorrect(incorrect1), .locked_out(locked1),
    .entry_timeout(timeout1), .fail_count(failCount1)
  );

  param_unlock_fsm #(
    .PWD_LEN(6), .PASSWORD(6'b110010), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(0)
  ) dutB (
    .clk(clk), .reset(reset),
    .serial_valid(valid2), .serial_data(data2), .serial_ready(ready2),
    .unlock(unlock2), .pwd_incorrect(incorrect2), .locked_out(locked2),
    .entry_timeout(timeout2), .fail_count(failCount2)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Drive one beat shortly after the rising edge. The next rising edge captures it.
  task automatic applyStimulus(input logic sel, input logic v, input logic d);
    @(posedge clk);
    #1;
    if (sel) begin valid2 = v; data2 = d; valid1 = 1'b0; end
    else     begin valid1 = v; data1 = d; valid2 = 1'b0; end
  endtask

  task automatic sendBeat1(input logic d, input logic expU, input logic expI, input string tag);
    applyStimulus(1'b0, 1'b1, d);
    @(negedge clk);
    checkOutput({tag, "_unlock"}, 32'(unlock1), 32'(expU));
    checkOutput({tag, "_incorrect"}, 32'(incorrect1), 32'(expI));
  endtask

  task automatic sendBeat2(input logic d, input logic expU, input logic expI, input string tag);
    applyStimulus(1'b1, 1'b1, d);
    @(negedge clk);
    checkOutput({tag, "_unlock"}, 32'(unlock2), 32'(expU));
    checkOutput({tag, "_incorrect"}, 32'(incorrect2), 32'(expI));
  endtask

  task automatic sendWord1(input logic [3:0] w, input logic expU, input logic expI, input string tag);
    for (int i = 3; i >= 1; i--) sendBeat1(w[i], 1'b0, 1'b0, tag);
    sendBeat1(w[0], expU, expI, tag);
  endtask

  task automatic idleCheck1(input logic [1:0] expFail, input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_fail"}, 32'(failCount1), 32'(expFail));
  endtask

  initial begin
    reset = 1'b0; valid1 = 1'b0; data1 = 1'b0; valid2 = 1'b0; data2 = 1'b0;

    // Values while reset is held.
    #3;
    checkOutput("rst_ready", 32'(ready1), 0);
    checkOutput("rst_unlock", 32'(unlock1), 0);
    checkOutput("rst_incorrect", 32'(incorrect1), 0);
    checkOutput("rst_locked", 32'(locked1), 0);
    checkOutput("rst_timeout", 32'(timeout1), 0);
    checkOutput("rst_fail", 32'(failCount1), 0);
    checkOutput("rst_readyB", 32'(ready2), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("post_rst_ready", 32'(ready1), 1);

    // A correct entry unlocks on the fourth beat only.
    sendWord1(4'b1011, 1'b1, 1'b0, "ok1");
    idleCheck1(2'd0, "ok1");

    // A wrong entry counts a failure. A later correct entry clears the count.
    sendWord1(4'b1001, 1'b0, 1'b1, "bad1");
    idleCheck1(2'd1, "bad1");
    sendWord1(4'b1011, 1'b1, 1'b0, "ok2");
    idleCheck1(2'd0, "ok2");

    // Three wrong entries lead to a 16-cycle lockout.
    sendWord1(4'b0000, 1'b0, 1'b1, "lk1");
    idleCheck1(2'd1, "lk1");
    sendWord1(4'b0000, 1'b0, 1'b1, "lk2");
    idleCheck1(2'd2, "lk2");
    sendWord1(4'b0000, 1'b0, 1'b1, "lk3");
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("lock%0d_locked", k), 32'(locked1), 1);
      checkOutput($sformatf("lock%0d_ready", k), 32'(ready1), 0);
      checkOutput($sformatf("lock%0d_unlock", k), 32'(unlock1), 0);
      checkOutput($sformatf("lock%0d_fail", k), 32'(failCount1), 3);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("unlock_exit_locked", 32'(locked1), 0);
    checkOutput("unlock_exit_ready", 32'(ready1), 1);
    checkOutput("unlock_exit_fail", 32'(failCount1), 0);
    sendWord1(4'b1011, 1'b1, 1'b0, "after_lock");

    // An idle gap of 8 cycles discards the partial entry.
    sendBeat1(1'b1, 1'b0, 1'b0, "to_b1");
    sendBeat1(1'b0, 1'b0, 1'b0, "to_b2");
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("to_idle%0d", k), 32'(timeout1), 32'(k == 9));
    end
    checkOutput("to_fail", 32'(failCount1), 0);
    sendWord1(4'b1011, 1'b1, 1'b0, "to_after");

    // An idle gap of 7 cycles keeps the partial entry.
    sendBeat1(1'b1, 1'b0, 1'b0, "nto_b1");
    sendBeat1(1'b0, 1'b0, 1'b0, "nto_b2");
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("nto_idle%0d", k), 32'(timeout1), 0);
    end
    sendBeat1(1'b1, 1'b0, 1'b0, "nto_b3");
    sendBeat1(1'b1, 1'b1, 1'b0, "nto_b4");
    idleCheck1(2'd0, "nto");
    checkOutput("nto_timeout", 32'(timeout1), 0);

    // Reset in the middle of an entry discards it and suppresses the pulses.
    sendBeat1(1'b1, 1'b0, 1'b0, "mr_b1");
    sendBeat1(1'b0, 1'b0, 1'b0, "mr_b2");
    @(posedge clk);
    #1;
    reset = 1'b0; valid1 = 1'b1; data1 = 1'b1;
    #1;
    checkOutput("mr_ready", 32'(ready1), 0);
    checkOutput("mr_unlock", 32'(unlock1), 0);
    checkOutput("mr_incorrect", 32'(incorrect1), 0);
    @(negedge clk);
    valid1 = 1'b0;
    reset  = 1'b1;
    sendWord1(4'b1011, 1'b1, 1'b0, "mr_after");

    // Six-bit password with the timeout disabled: long gaps are harmless.
    sendBeat2(1'b1, 1'b0, 1'b0, "b6_1");
    sendBeat2(1'b1, 1'b0, 1'b0, "b6_2");
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("b6_idle%0d", k), 32'(timeout2), 0);
    end
    sendBeat2(1'b0, 1'b0, 1'b0, "b6_3");
    sendBeat2(1'b0, 1'b0, 1'b0, "b6_4");
    sendBeat2(1'b1, 1'b0, 1'b0, "b6_5");
    sendBeat2(1'b0, 1'b1, 1'b0, "b6_6");
    sendBeat2(1'b1, 1'b0, 1'b0, "w6_1");
    sendBeat2(1'b1, 1'b0, 1'b0, "w6_2");
    sendBeat2(1'b0, 1'b0, 1'b0, "w6_3");
    sendBeat2(1'b0, 1'b0, 1'b0, "w6_4");
    sendBeat2(1'b1, 1'b0, 1'b0, "w6_5");
    sendBeat2(1'b1, 1'b0, 1'b1, "w6_6");
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("w6_fail", 32'(failCount2), 1);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
